note_source_arbiter: RTL and testbench

Shares the single tone generator and 7-segment note display between three note sources: live keyboard scanner, piano recorder playback and song player. A registered FSM grants one source, forces a muted gap on every source change so the buzzer never switches glitchily, and drives the unified key/octave bus that feeds the buzzer divider and display controller. It sits between the source blocks and the buzzer/display logic, and replaces the combinational priority mux.

---
 rtl/piano_pkg.sv | 49 ++++
 rtl/arb_gap_timer.sv | 31 +++
 rtl/note_source_arbiter.sv | 155 +++++++++++++++
 tb/tb_note_source_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared constants for the piano datapath: note-source codes, key-ID limits
// and buzzer half-period counts for a 50 MHz clock.
package piano_pkg;

    typedef enum logic [1:0] {
        SRC_LIVE = 2'd0,
        SRC_PLAY = 2'd1,
        SRC_SONG = 2'd2,
        SRC_GAP  = 2'd3
    } src_e;

    localparam int KEY_ID_REST = 0;
    localparam int MAX_KEY_ID  = 12;

    localparam int CLK_HZ = 50_000_000;

    // Half-period counts (CLK_HZ / (2 * f)) for the base octave C4..B4.
    localparam int HALF_PERIOD_C4  = 95556;
    localparam int HALF_PERIOD_CS4 = 90193;
    localparam int HALF_PERIOD_D4  = 85131;
    localparam int HALF_PERIOD_DS4 = 80353;
    localparam int HALF_PERIOD_E4  = 75843;
    localparam int HALF_PERIOD_F4  = 71586;
    localparam int HALF_PERIOD_FS4 = 67568;
    localparam int HALF_PERIOD_G4  = 63776;
    localparam int HALF_PERIOD_GS4 = 60197;
    localparam int HALF_PERIOD_A4  = 56818;
    localparam int HALF_PERIOD_AS4 = 53630;
    localparam int HALF_PERIOD_B4  = 50619;

    function automatic int half_period(input int key_id);
        case (key_id)
            1:       return HALF_PERIOD_C4;
            2:       return HALF_PERIOD_CS4;
            3:       return HALF_PERIOD_D4;
            4:       return HALF_PERIOD_DS4;
            5:       return HALF_PERIOD_E4;
            6:       return HALF_PERIOD_F4;
            7:       return HALF_PERIOD_FS4;
            8:       return HALF_PERIOD_G4;
            9:       return HALF_PERIOD_GS4;
            10:      return HALF_PERIOD_A4;
            11:      return HALF_PERIOD_AS4;
            12:      return HALF_PERIOD_B4;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/arb_gap_timer.sv
// Loadable down-counter that measures the muted gap between note sources;
// zero is high whenever the count has run out.
module arb_gap_timer
    import piano_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is written with <= so every register samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/note_source_arbiter.sv
// Grants the tone generator/display to live keys, playback or song player with a muted gap on
// every switch. Define ARB_LIVE_ABORT_EN to let a live key press abort playback/song.
module note_source_arbiter
    import piano_pkg::*;
#(
    parameter int KEY_ID_BITS = 4,
    parameter int MAX_KEY_ID  = piano_pkg::MAX_KEY_ID,
    parameter int GAP_CYCLES  = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_ID_BITS-1:0] live_key_id,
    input  logic                   live_key_pressed,
    input  logic                   live_oct_up,
    input  logic                   live_oct_down,
    input  logic                   play_active,
    input  logic [KEY_ID_BITS-1:0] play_key_id,
    input  logic                   play_key_pressed,
    input  logic                   play_oct_up,
    input  logic                   play_oct_down,
    input  logic                   song_active,
    input  logic [KEY_ID_BITS-1:0] song_key_id,
    input  logic                   song_key_pressed,
    output logic [KEY_ID_BITS-1:0] out_key_id,
    output logic                   out_key_pressed,
    output logic                   out_oct_up,
    output logic                   out_oct_down,
    output logic [1:0]             active_source,
    output logic                   abort_pulse
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    src_e                   state, next_state, target;
    logic                   abort_now, lockout;
    logic                   gap_load, gap_zero;
    logic [KEY_ID_BITS-1:0] sel_id;
    logic                   sel_pressed, sel_up, sel_down, silent;

    arb_gap_timer #(.WIDTH(GAP_W)) u_gap_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .dec        (state == SRC_GAP),
        .zero       (gap_zero)
    );

`ifdef ARB_LIVE_ABORT_EN
    logic live_pressed_q, abort_q;

    assign abort_now = ((state == SRC_PLAY) || (state == SRC_SONG))
                       && live_key_pressed && !live_pressed_q;

    // Lockout keeps an aborted source from regaining the grant until both requests have dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live_pressed_q <= 1'b0;
            abort_q        <= 1'b0;
            lockout        <= 1'b0;
        end else begin
            live_pressed_q <= live_key_pressed;
            abort_q        <= abort_now;
            if (abort_now) begin
                lockout <= 1'b1;
            end else if (!play_active && !song_active) begin
                lockout <= 1'b0;
            end
        end
    end

    assign abort_pulse = abort_q;
`else
    assign abort_now   = 1'b0;
    assign lockout     = 1'b0;
    assign abort_pulse = 1'b0;
`endif

    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        target     = SRC_LIVE;
        next_state = state;
        gap_load   = 1'b0;

        if (song_active && !lockout) begin
            target = SRC_SONG;
        end else if (play_active && !lockout) begin
            target = SRC_PLAY;
        end
        if (abort_now) begin
            target = SRC_LIVE;
        end

        if (state == SRC_GAP) begin
            if (gap_zero) begin
                next_state = target;
            end
        end else if (target != state) begin
            if (GAP_CYCLES > 0) begin
                next_state = SRC_GAP;
                gap_load   = 1'b1;
            end else begin
                next_state = target;
            end
        end
    end

    // Outputs follow the state being entered, so the data and active_source change on the same edge.
    always_comb begin
        sel_id      = '0;
        sel_pressed = 1'b0;
        sel_up      = 1'b0;
        sel_down    = 1'b0;
        case (next_state)
            SRC_LIVE: begin
                sel_id      = live_key_id;
                sel_pressed = live_key_pressed;
                sel_up      = live_oct_up;
                sel_down    = live_oct_down;
            end
            SRC_PLAY: begin
                sel_id      = play_key_id;
                sel_pressed = play_key_pressed;
                sel_up      = play_oct_up;
                sel_down    = play_oct_down;
            end
            SRC_SONG: begin
                sel_id      = song_key_id;
                sel_pressed = song_key_pressed;
            end
            default: ;
        endcase
        silent = (int'(sel_id) == KEY_ID_REST) || (int'(sel_id) > MAX_KEY_ID);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= SRC_LIVE;
            out_key_id      <= '0;
            out_key_pressed <= 1'b0;
            out_oct_up      <= 1'b0;
            out_oct_down    <= 1'b0;
        end else begin
            state           <= next_state;
            out_key_id      <= silent ? '0 : sel_id;
            out_key_pressed <= sel_pressed && !silent;
            out_oct_up      <= sel_up;
            out_oct_down    <= sel_down;
        end
    end

    assign active_source = state;

endmodule

// File: tb/tb_note_source_arbiter.sv
// Directed bench for note_source_arbiter with a cycle-stamped reference model and
// literal spot checks; follows ARB_LIVE_ABORT_EN when it is defined for the build.
module tb_note_source_arbiter;

    localparam int KB   = 4;
    localparam int MAXK = 12;
    localparam int GAP  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KB-1:0] live_key_id, play_key_id, song_key_id;
    logic          live_key_pressed, live_oct_up, live_oct_down;
    logic          play_active, play_key_pressed, play_oct_up, play_oct_down;
    logic          song_active, song_key_pressed;
    logic [KB-1:0] out_key_id;
    logic          out_key_pressed, out_oct_up, out_oct_down, abort_pulse;
    logic [1:0]    active_source;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    note_source_arbiter #(
        .KEY_ID_BITS (KB),
        .MAX_KEY_ID  (MAXK),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .live_key_id      (live_key_id),
        .live_key_pressed (live_key_pressed),
        .live_oct_up      (live_oct_up),
        .live_oct_down    (live_oct_down),
        .play_active      (play_active),
        .play_key_id      (play_key_id),
        .play_key_pressed (play_key_pressed),
        .play_oct_up      (play_oct_up),
        .play_oct_down    (play_oct_down),
        .song_active      (song_active),
        .song_key_id      (song_key_id),
        .song_key_pressed (song_key_pressed),
        .out_key_id       (out_key_id),
        .out_key_pressed  (out_key_pressed),
        .out_oct_up       (out_oct_up),
        .out_oct_down     (out_oct_down),
        .active_source    (active_source),
        .abort_pulse      (abort_pulse)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: grant is an integer source, a gap is a time window [start, start+GAP).
    int         m_cyc = 0;
    int         m_grant = 0;
    int         m_gap_end = 0;
    bit         m_in_gap = 1'b0;
    bit         m_lock = 1'b0;
    bit         m_live_q = 1'b0;
    logic [1:0] e_src = '0;
    int         e_id = 0;
    bit         e_pr = 1'b0, e_up = 1'b0, e_dn = 1'b0, e_ab = 1'b0;

    always @(posedge clk) begin
        int tgt;
        int id_v;
        bit pr_v, up_v, dn_v, ab_v;
        if (!rst_n) begin
            m_in_gap = 1'b0; m_grant = 0; m_lock = 1'b0; m_live_q = 1'b0;
            e_src = 2'd0; e_id = 0; e_pr = 1'b0; e_up = 1'b0; e_dn = 1'b0; e_ab = 1'b0;
        end else begin
            tgt  = (song_active && !m_lock) ? 2 : (play_active && !m_lock) ? 1 : 0;
            ab_v = 1'b0;
`ifdef ARB_LIVE_ABORT_EN
            if (!m_in_gap && m_grant != 0 && live_key_pressed && !m_live_q) ab_v = 1'b1;
`endif
            if (ab_v) tgt = 0;
            if (m_in_gap) begin
                if (m_cyc == m_gap_end) begin
                    m_in_gap = 1'b0;
                    m_grant  = tgt;
                end
            end else if (tgt != m_grant) begin
                if (GAP == 0) m_grant = tgt;
                else begin
                    m_in_gap  = 1'b1;
                    m_gap_end = m_cyc + GAP;
                end
            end
`ifdef ARB_LIVE_ABORT_EN
            if (ab_v) m_lock = 1'b1;
            else if (!play_active && !song_active) m_lock = 1'b0;
            m_live_q = live_key_pressed;
`endif
            case (m_grant)
                0: begin id_v = int'(live_key_id); pr_v = live_key_pressed; up_v = live_oct_up; dn_v = live_oct_down; end
                1: begin id_v = int'(play_key_id); pr_v = play_key_pressed; up_v = play_oct_up; dn_v = play_oct_down; end
                default: begin id_v = int'(song_key_id); pr_v = song_key_pressed; up_v = 1'b0; dn_v = 1'b0; end
            endcase
            if (m_in_gap) begin
                id_v = 0; pr_v = 1'b0; up_v = 1'b0; dn_v = 1'b0;
            end
            if (id_v == 0 || id_v > MAXK) begin
                id_v = 0; pr_v = 1'b0;
            end
            e_src = m_in_gap ? 2'd3 : 2'(m_grant);
            e_id  = id_v; e_pr = pr_v; e_up = up_v; e_dn = dn_v; e_ab = ab_v;
        end
        m_cyc++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle{ab,src,id,pr,up,dn}",
                  {abort_pulse, active_source, out_key_id, out_key_pressed, out_oct_up, out_oct_down},
                  {e_ab, e_src, 4'(e_id), e_pr, e_up, e_dn});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int src, input int id,
                              input bit pr, input bit up, input bit dn, input bit ab);
        @(negedge clk);
        check(name,
              {abort_pulse, active_source, out_key_id, out_key_pressed, out_oct_up, out_oct_down},
              {ab, 2'(src), 4'(id), pr, up, dn});
    endtask

    initial begin
        rst_n = 1'b0;
        live_key_id = 4'd5; live_key_pressed = 1'b1; live_oct_up = 1'b0; live_oct_down = 1'b0;
        play_active = 1'b0; play_key_id = 4'd0; play_key_pressed = 1'b0;
        play_oct_up = 1'b0; play_oct_down = 1'b0;
        song_active = 1'b0; song_key_id = 4'd0; song_key_pressed = 1'b0;

        step(1);
        cmp_en = 1'b1;
        expect_out("reset_hold", 0, 0, 0, 0, 0, 0);
        step(1);
        rst_n = 1'b1;
        step(1);  expect_out("live_after_reset", 0, 5, 1, 0, 0, 0);
        live_oct_up = 1'b1; live_oct_down = 1'b1;
        step(1);  expect_out("live_both_oct", 0, 5, 1, 1, 1, 0);
        live_oct_up = 1'b0; live_oct_down = 1'b0;

        for (int k = 0; k < 16; k++) begin
            live_key_id = 4'(k);
            step(1);
        end
        live_key_id = 4'd13;
        step(1);  expect_out("live_id13_silent", 0, 0, 0, 0, 0, 0);
        live_key_id = 4'd5;

        play_key_id = 4'd3; play_key_pressed = 1'b1; play_active = 1'b1;
        step(1);  expect_out("play_gap_first", 3, 0, 0, 0, 0, 0);
        step(3);  expect_out("play_gap_last", 3, 0, 0, 0, 0, 0);
        step(1);  expect_out("play_grant", 1, 3, 1, 0, 0, 0);
        play_oct_up = 1'b1;
        step(1);  expect_out("play_oct_up", 1, 3, 1, 1, 0, 0);

        song_key_id = 4'd8; song_key_pressed = 1'b1; song_active = 1'b1;
        step(1);  expect_out("song_gap", 3, 0, 0, 0, 0, 0);
        step(4);  expect_out("song_grant", 2, 8, 1, 0, 0, 0);
        song_key_id = 4'd13;
        step(1);  expect_out("song_id13", 2, 0, 0, 0, 0, 0);
        song_key_id = 4'd0;
        step(1);  expect_out("song_id0", 2, 0, 0, 0, 0, 0);
        song_key_id = 4'd12;
        step(1);  expect_out("song_id12", 2, 12, 1, 0, 0, 0);

        song_active = 1'b0;
        step(5);  expect_out("back_to_play", 1, 3, 1, 1, 0, 0);
        play_active = 1'b0; play_oct_up = 1'b0;
        step(5);  expect_out("back_to_live", 0, 5, 1, 0, 0, 0);

        play_active = 1'b1; song_active = 1'b1;
        step(5);  expect_out("simul_song", 2, 12, 1, 0, 0, 0);
        song_active = 1'b0;
        step(1);  expect_out("simul_gap", 3, 0, 0, 0, 0, 0);
        step(4);  expect_out("simul_play", 1, 3, 1, 0, 0, 0);

        play_active = 1'b0;
        step(2);  expect_out("mid_gap", 3, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step(1);  expect_out("reset_mid_gap", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1);  expect_out("live_after_gap_reset", 0, 5, 1, 0, 0, 0);

        live_key_pressed = 1'b0; live_key_id = 4'd2; play_active = 1'b1;
        step(5);  expect_out("abort_setup", 1, 3, 1, 0, 0, 0);
        live_key_pressed = 1'b1;
`ifdef ARB_LIVE_ABORT_EN
        step(1);  expect_out("abort_pulse", 3, 0, 0, 0, 0, 1);
        step(1);  expect_out("abort_one_cycle", 3, 0, 0, 0, 0, 0);
        step(3);  expect_out("abort_live", 0, 2, 1, 0, 0, 0);
        step(3);  expect_out("lockout_hold", 0, 2, 1, 0, 0, 0);
        play_active = 1'b0;
        step(1);
        play_active = 1'b1;
        step(1);  expect_out("relock_gap", 3, 0, 0, 0, 0, 0);
        step(4);  expect_out("after_lockout", 1, 3, 1, 0, 0, 0);
`else
        step(1);  expect_out("no_abort", 1, 3, 1, 0, 0, 0);
        step(1);  expect_out("no_abort_hold", 1, 3, 1, 0, 0, 0);
        step(3);  expect_out("no_abort_grant", 1, 3, 1, 0, 0, 0);
`endif
        play_active = 1'b0;
        step(6);  expect_out("final_live", 0, 2, 1, 0, 0, 0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
